// File: rtl/seq_pattern_tx.sv
`default_nettype none
// ============================================================================
//  Module   : seq_pattern_tx
//  Purpose  : Serial frame transmitter. Each frame is the sync word (MSB
//             first), then a parallel-loaded payload (MSB first), then
//             GAP_CYCLES idle zeros. Drives one bit per clock.
//  Ports    : clk          - system clock, rising edge
//             reset        - synchronous, active-high reset
//             load_valid   - payload offered for transmission
//             load_data    - payload word, sampled only on accept
//             load_ready   - block can accept a payload this cycle (comb)
//             data_out     - serial bit stream (registered)
//             bit_valid    - data_out carries a sync or payload bit
//             sync_active  - data_out carries a sync bit
//             frame_done   - one-cycle pulse with the last payload bit
//             busy         - frame in progress (state other than IDLE)
//  Revision : 1.0 - initial release
// ============================================================================
module seq_pattern_tx #(
  parameter int                SYNC_W       = 4,
  parameter logic [SYNC_W-1:0] SYNC_PATTERN = 4'b1101,
  parameter int                PAYLOAD_W    = 8,
  parameter int                GAP_CYCLES   = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_valid,
  input  logic [PAYLOAD_W-1:0] load_data,
  output logic                 load_ready,
  output logic                 data_out,
  output logic                 bit_valid,
  output logic                 sync_active,
  output logic                 frame_done,
  output logic                 busy
);

  localparam int MAX_A = (SYNC_W > PAYLOAD_W) ? SYNC_W : PAYLOAD_W;
  localparam int MAX_B = (MAX_A > GAP_CYCLES) ? MAX_A : GAP_CYCLES;
  localparam int MAX_C = (MAX_B > 1) ? MAX_B : 1;
  localparam int CNT_W = $clog2(MAX_C + 1);
  localparam int SH_W  = SYNC_W + PAYLOAD_W;

  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] SYNC_LAST    = CNT_W'(SYNC_W - 1);
  localparam logic [CNT_W-1:0] PAYLOAD_LAST = CNT_W'(PAYLOAD_W - 1);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SYNC    = 2'd1,
    PAYLOAD = 2'd2,
    GAP     = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SH_W-1:0]   sh_q, sh_d;
  logic              data_q, data_d;
  logic              bv_q, bv_d;
  logic              sa_q, sa_d;
  logic              fd_q, fd_d;
  logic              busy_q, busy_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      data_q  <= 1'b0;
      bv_q    <= 1'b0;
      sa_q    <= 1'b0;
      fd_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      bv_q    <= bv_d;
      sa_q    <= sa_d;
      fd_q    <= fd_d;
      busy_q  <= busy_d;
    end
  end

  // Sync word and payload share one shift register: the sync word is
  // loaded above the payload so both phases simply emit the MSB.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    data_d  = 1'b0;
    bv_d    = 1'b0;
    sa_d    = 1'b0;
    fd_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_valid) begin
          sh_d    = {SYNC_PATTERN, load_data};
          cnt_d   = '0;
          state_d = SYNC;
        end
      end
      SYNC: begin
        data_d = sh_q[SH_W-1];
        bv_d   = 1'b1;
        sa_d   = 1'b1;
        sh_d   = {sh_q[SH_W-2:0], 1'b0};
        if (cnt_q == SYNC_LAST) begin
          cnt_d   = '0;
          state_d = PAYLOAD;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      PAYLOAD: begin
        data_d = sh_q[SH_W-1];
        bv_d   = 1'b1;
        sh_d   = {sh_q[SH_W-2:0], 1'b0};
        if (cnt_q == PAYLOAD_LAST) begin
          fd_d    = 1'b1;
          cnt_d   = '0;
          state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
    // busy reflects the state the register will hold after this edge
    busy_d = (state_d != IDLE);
  end

  assign load_ready  = (state_q == IDLE);
  assign data_out    = data_q;
  assign bit_valid   = bv_q;
  assign sync_active = sa_q;
  assign frame_done  = fd_q;
  assign busy        = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_pattern_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_pattern_tx
//  Purpose  : Self-checking bench for seq_pattern_tx. Instance u_a uses the
//             default parameters and is checked every cycle against a
//             timeline model; instance u_b uses PAYLOAD_W=4, GAP_CYCLES=0
//             with continuous loads.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seq_pattern_tx;

  localparam int         S     = 4;
  localparam int         P     = 8;
  localparam int         G     = 2;
  localparam logic [3:0] SP    = 4'b1101;
  localparam int         DEPTH = 2048;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // instance A (defaults)
  logic       reset, load_valid;
  logic [7:0] load_data;
  logic       load_ready, data_out, bit_valid, sync_active, frame_done, busy;

  // instance B (short payload, no gap)
  logic       rst_b, lv_b;
  logic [3:0] ld_b;
  logic       ready_b, data_b, bv_b, sa_b, fd_b, busy_b;

  seq_pattern_tx u_a (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .data_out(data_out), .bit_valid(bit_valid),
    .sync_active(sync_active), .frame_done(frame_done), .busy(busy)
  );

  seq_pattern_tx #(.PAYLOAD_W(4), .GAP_CYCLES(0)) u_b (
    .clk(clk), .reset(rst_b), .load_valid(lv_b), .load_data(ld_b),
    .load_ready(ready_b), .data_out(data_b), .bit_valid(bv_b),
    .sync_active(sa_b), .frame_done(fd_b), .busy(busy_b)
  );

  // Expected output timeline for instance A, indexed by edge number.
  bit   e_d[DEPTH], e_bv[DEPTH], e_sa[DEPTH], e_fd[DEPTH], e_busy[DEPTH];
  int   free_at;
  int   cyc;
  int   n_pass, n_total;
  int   n_acc;
  bit   accepted;
  logic [3:0]  win;
  logic [11:0] cap;
  int   nbits, nfd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
  endtask

  // Apply the frame rules to one edge of instance A.
  task automatic model_edge(input logic r, input logic lv, input logic [7:0] ld);
    accepted = 1'b0;
    if (r) begin
      for (int i = cyc; i < cyc + 64 && i < DEPTH; i++) begin
        e_d[i] = 0; e_bv[i] = 0; e_sa[i] = 0; e_fd[i] = 0; e_busy[i] = 0;
      end
      free_at = cyc + 1;
    end else if (lv && cyc >= free_at) begin
      accepted = 1'b1;
      for (int o = 1; o <= S; o++) begin
        e_d[cyc+o] = SP[S-o]; e_bv[cyc+o] = 1; e_sa[cyc+o] = 1;
      end
      for (int o = 1; o <= P; o++) begin
        e_d[cyc+S+o] = ld[P-o]; e_bv[cyc+S+o] = 1; e_fd[cyc+S+o] = (o == P);
      end
      for (int i = cyc; i < cyc + S + P + G; i++) e_busy[i] = 1;
      free_at = cyc + S + P + G + 1;
    end
  endtask

  task automatic check_a();
    chk("data_out",    {31'd0, data_out},    {31'd0, e_d[cyc]});
    chk("bit_valid",   {31'd0, bit_valid},   {31'd0, e_bv[cyc]});
    chk("sync_active", {31'd0, sync_active}, {31'd0, e_sa[cyc]});
    chk("frame_done",  {31'd0, frame_done},  {31'd0, e_fd[cyc]});
    chk("busy",        {31'd0, busy},        {31'd0, e_busy[cyc]});
    chk("load_ready",  {31'd0, load_ready},  {31'd0, (cyc + 1 >= free_at)});
    // stand-in 1101 detector on the line: must fire at each sync word end
    win = {win[2:0], data_out};
    if (e_sa[cyc] && !e_sa[cyc+1]) chk("sync_detect", {28'd0, win}, {28'd0, SP});
  endtask

  task automatic step(input logic r, input logic lv, input logic [7:0] ld);
    reset = r; load_valid = lv; load_data = ld;
    @(posedge clk);
    cyc++;
    model_edge(r, lv, ld);
    #1;
    check_a();
  endtask

  int o;
  logic [7:0] pat8;

  initial begin
    reset = 1'b1; load_valid = 1'b0; load_data = '0;
    rst_b = 1'b1; lv_b = 1'b0; ld_b = 4'b1101;
    cyc = 0; n_pass = 0; n_total = 0; n_acc = 0; free_at = 0; win = '0;
    pat8 = 8'b11011101;

    // reset state
    step(1, 0, 8'h00);
    step(1, 0, 8'h00);

    // frame with A5, collected independently of the model
    step(0, 1, 8'hA5);
    cap = '0; nbits = 0; nfd = 0;
    for (int i = 0; i < 14; i++) begin
      step(0, 0, 8'h00);
      if (bit_valid === 1'b1) begin cap = {cap[10:0], data_out}; nbits++; end
      if (frame_done === 1'b1) nfd++;
    end
    chk("t1_bits",  {20'd0, cap}, {20'd0, 12'b110110100101});
    chk("t1_nbits", nbits, 12);
    chk("t1_nfd",   nfd, 1);

    // load_valid held: back-to-back frames 3C then C3
    step(0, 1, 8'h3C);
    for (int i = 0; i < 14; i++) step(0, 1, 8'hC3);
    step(0, 1, 8'hC3);
    for (int i = 0; i < 16; i++) step(0, 0, 8'h00);

    // mid-frame offer ignored
    step(0, 1, 8'hA5);
    for (int i = 0; i < 4; i++) step(0, 0, 8'h00);
    step(0, 1, 8'hFF);
    for (int i = 0; i < 20; i++) step(0, 0, 8'h00);

    // reset mid-payload, then clean frame
    step(0, 1, 8'h5A);
    for (int i = 0; i < 7; i++) step(0, 0, 8'h00);
    step(1, 0, 8'h00);
    step(0, 1, 8'h0F);
    for (int i = 0; i < 16; i++) step(0, 0, 8'h00);

    // reset together with load_valid: nothing accepted
    step(1, 1, 8'hAA);
    step(0, 0, 8'h00);
    step(0, 0, 8'h00);

    // randomized traffic with occasional resets
    n_acc = 0;
    while (n_acc < 20 && cyc < 1800) begin
      step(($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0,
           1'($urandom_range(0, 1)), 8'($urandom));
      if (accepted) n_acc++;
    end
    chk("rand_budget", {31'd0, (n_acc >= 20)}, 32'd1);
    for (int i = 0; i < 16; i++) step(0, 0, 8'h00);

    // instance B: continuous 1101 loads, PAYLOAD_W=4, no gap
    reset = 1'b1;
    @(posedge clk); #1;
    chk("b_rst_data",  {31'd0, data_b},  32'd0);
    chk("b_rst_busy",  {31'd0, busy_b},  32'd0);
    chk("b_rst_ready", {31'd0, ready_b}, 32'd1);
    rst_b = 1'b0; lv_b = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 27; k++) begin
      o = k % 9;
      chk("b_data",  {31'd0, data_b},  {31'd0, (o >= 1) ? pat8[8-o] : 1'b0});
      chk("b_bv",    {31'd0, bv_b},    {31'd0, (o != 0)});
      chk("b_sa",    {31'd0, sa_b},    {31'd0, (o >= 1 && o <= 4)});
      chk("b_fd",    {31'd0, fd_b},    {31'd0, (o == 8)});
      chk("b_busy",  {31'd0, busy_b},  {31'd0, (o != 8)});
      chk("b_ready", {31'd0, ready_b}, {31'd0, (o == 8)});
      @(posedge clk); #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
